// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: signed dot product plus bias, optional ReLU, output saturation.
// LANES products are folded into the accumulator per cycle, with valid/ready on both sides.
module neuron_mac_seq #(
    parameter int N_IN    = 4,
    parameter int IN_W    = 12,
    parameter int W_W     = 5,
    parameter int OUT_W   = 17,
    parameter int ACC_W   = 20,
    parameter int LANES   = 1,
    parameter int RELU_EN = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN*IN_W-1:0]   in_vec,
    input  logic [N_IN*W_W-1:0]    w_vec,
    input  logic [OUT_W-1:0]       bias,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_sat
);
    localparam int PROD_W = IN_W + W_W;
    localparam int IDX_W  = $clog2(N_IN + 1);
    localparam logic signed [ACC_W-1:0] MAXV =
        ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [N_IN*IN_W-1:0]     r_in;
    logic [N_IN*W_W-1:0]      r_w;
    logic signed [ACC_W-1:0]  r_acc;
    logic [IDX_W-1:0]         r_idx;
    logic [OUT_W-1:0]         r_out_data;
    logic                     r_out_sat;

    logic                     w_accept;
    logic                     w_load_out;
    logic                     w_last;
    logic signed [IN_W-1:0]   w_a;
    logic signed [W_W-1:0]    w_b;
    logic signed [PROD_W-1:0] w_p;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic signed [ACC_W-1:0]  w_relu;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic [OUT_W-1:0]         w_sat_data;
    logic                     w_sat;

    assign w_last     = (32'(r_idx) + LANES) == N_IN;
    assign w_bias_ext = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias};
    assign out_data   = r_out_data;
    assign out_sat    = r_out_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_load_out  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                if (w_last) begin
                    w_load_out  = 1'b1;
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Full-width products, sign-extended before summing
    always_comb begin
        w_sum = '0;
        w_a   = '0;
        w_b   = '0;
        w_p   = '0;
        for (int l = 0; l < LANES; l++) begin
            w_a   = r_in[(32'(r_idx) + l) * IN_W +: IN_W];
            w_b   = r_w[(32'(r_idx) + l) * W_W +: W_W];
            w_p   = w_a * w_b;
            w_sum = w_sum + ACC_W'(w_p);
        end
    end

    always_comb begin
        w_acc_nxt  = r_acc + w_sum;
        w_relu     = (RELU_EN != 0 && w_acc_nxt < 0) ? '0 : w_acc_nxt;
        w_sat      = 1'b0;
        w_sat_data = w_relu[OUT_W-1:0];
        if (w_relu > MAXV) begin
            w_sat      = 1'b1;
            w_sat_data = MAXV[OUT_W-1:0];
        end else if (w_relu < MINV) begin
            w_sat      = 1'b1;
            w_sat_data = MINV[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in       <= '0;
            r_w        <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_in  <= in_vec;
                r_w   <= w_vec;
                r_acc <= w_bias_ext;
                r_idx <= '0;
            end else if (r_state == S_ACC) begin
                r_acc <= w_acc_nxt;
                r_idx <= r_idx + IDX_W'(LANES);
            end
            if (w_load_out) begin
                r_out_data <= w_sat_data;
                r_out_sat  <= w_sat;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: default, ReLU and 4-lane instances
// share operand buses; each has its own handshake signals.
module tb_neuron_mac_seq;
    logic              clk;
    logic              rst_n;
    logic [47:0]       in_vec;
    logic [19:0]       w_vec;
    logic [16:0]       bias;
    logic              iv  [3];
    logic              ir  [3];
    logic              ov  [3];
    logic              orr [3];
    logic [16:0]       od  [3];
    logic              os  [3];

    int n_chk = 0;
    int n_err = 0;

    neuron_mac_seq u0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .in_vec(in_vec), .w_vec(w_vec), .bias(bias),
        .out_valid(ov[0]), .out_ready(orr[0]),
        .out_data(od[0]), .out_sat(os[0])
    );

    neuron_mac_seq #(.RELU_EN(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .in_vec(in_vec), .w_vec(w_vec), .bias(bias),
        .out_valid(ov[1]), .out_ready(orr[1]),
        .out_data(od[1]), .out_sat(os[1])
    );

    neuron_mac_seq #(.LANES(4)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(ir[2]),
        .in_vec(in_vec), .w_vec(w_vec), .bias(bias),
        .out_valid(ov[2]), .out_ready(orr[2]),
        .out_data(od[2]), .out_sat(os[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_ops(input int a0, input int a1, input int a2, input int a3,
                           input int b0, input int b1, input int b2, input int b3,
                           input int bs);
        in_vec = {12'(a3), 12'(a2), 12'(a1), 12'(a0)};
        w_vec  = {5'(b3), 5'(b2), 5'(b1), 5'(b0)};
        bias   = 17'(bs);
    endtask

    // Accept cycle is cycle 0; lat is the cycle in which out_valid is first seen.
    task automatic run(input int d, input int lat_exp,
                       input logic signed [63:0] dexp,
                       input logic sexp, input string tag);
        int lat;
        iv[d] = 1'b1;
        @(negedge clk);
        iv[d] = 1'b0;
        lat = 1;
        while (!ov[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, lat, lat_exp);
        chk({tag, ".data"}, $signed(od[d]), dexp);
        chk({tag, ".sat"}, os[d], sexp);
        @(negedge clk);
        chk({tag, ".valid_drop"}, ov[d], 0);
        chk({tag, ".ready_back"}, ir[d], 1);
    endtask

    initial begin
        int k;
        logic seen;
        int acc_c[$];
        int out_c[$];

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i]  = 1'b0;
            orr[i] = 1'b1;
        end
        set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.valid", ov[0], 0);
        chk("rst.data", $signed(od[0]), 0);
        chk("rst.sat", os[0], 0);
        chk("rst.ready", ir[0], 1);
        chk("rst.ready_l4", ir[2], 1);

        set_ops(1, 2, 3, 4, 1, 1, 1, 1, 0);
        run(0, 5, 10, 1'b0, "t1");

        set_ops(-2048, -2048, -2048, -2048, -16, -16, -16, -16, 65535);
        run(0, 5, 65535, 1'b1, "t2pos");
        set_ops(-2048, -2048, -2048, -2048, 15, 15, 15, 15, -65536);
        run(0, 5, -65536, 1'b1, "t2neg");

        set_ops(100, 100, 100, 100, -1, -1, -1, -1, 5);
        run(1, 5, 0, 1'b0, "t3relu");
        run(0, 5, -395, 1'b0, "t3lin");

        // Backpressure with a stray in_valid pulse while the result is held
        set_ops(1, 2, 3, 4, 1, 1, 1, 1, 0);
        orr[0] = 1'b0;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        k = 1;
        while (!ov[0] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t4.valid", ov[0], 1);
        set_ops(7, 7, 7, 7, 7, 7, 7, 7, 7);
        for (int i = 0; i < 4; i++) begin
            iv[0] = (i == 1);
            chk("t4.hold_data", $signed(od[0]), 10);
            chk("t4.hold_valid", ov[0], 1);
            chk("t4.hold_ready", ir[0], 0);
            @(negedge clk);
        end
        iv[0] = 1'b0;
        chk("t4.still_data", $signed(od[0]), 10);
        orr[0] = 1'b1;
        @(negedge clk);
        chk("t4.idle_valid", ov[0], 0);
        chk("t4.idle_ready", ir[0], 1);
        @(negedge clk);
        chk("t4.no_accept", ir[0], 1);

        // Reset during ACC at idx=2
        set_ops(1, 2, 3, 4, 1, 1, 1, 1, 0);
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5.rst_data", $signed(od[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5.valid", ov[0], 0);
        chk("t5.data", $signed(od[0]), 0);
        chk("t5.ready", ir[0], 1);
        seen = 1'b0;
        repeat (6) begin
            if (ov[0]) seen = 1'b1;
            @(negedge clk);
        end
        chk("t5.no_result", seen, 0);
        run(0, 5, 10, 1'b0, "t5again");

        set_ops(3, -5, 7, -1, 2, 2, -1, 4, -1);
        run(2, 2, -16, 1'b0, "t6");

        iv[2] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (ir[2]) acc_c.push_back(c);
            if (ov[2]) begin
                out_c.push_back(c);
                chk("t6.b2b_data", $signed(od[2]), -16);
            end
            @(negedge clk);
        end
        iv[2] = 1'b0;
        chk("t6.accepts", acc_c.size(), 4);
        chk("t6.results", out_c.size(), 3);
        chk("t6.acc_gap1",
            (acc_c.size() >= 2) ? acc_c[1] - acc_c[0] : -1, 3);
        chk("t6.acc_gap2",
            (acc_c.size() >= 3) ? acc_c[2] - acc_c[1] : -1, 3);
        chk("t6.out_gap",
            (out_c.size() >= 2) ? out_c[1] - out_c[0] : -1, 3);
        chk("t6.first_out",
            (out_c.size() >= 1) ? out_c[0] : -1, 2);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
